multi_channel_debouncer: RTL and testbench
==========================================

# multi_channel_debouncer

Parametrised N-channel input conditioner that succeeds the single-channel pulse cleaner. Each channel has a metastability synchroniser, a symmetric debounce filter for both edges and a held debounced level. Outputs are one-cycle pulses for rising edges, falling edges and long-press (hold) events. It sits between raw board inputs (buttons, switches, slow external strobes) and control logic that consumes clean levels and single-cycle events.

## Interface
Parameters:
- CHANNELS, 4: number of independent input channels (≥1)
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- DEBOUNCE_CNT, 4: consecutive differing synchronised samples required to accept a new level (≥1)
- HOLD_CNT, 16: cycles of continuous debounced-high after the rise before hold_pulse fires; 0 disables hold detection

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- noisy_in  in  CHANNELS  raw asynchronous inputs, bit i = channel i
- stable_out  out  CHANNELS  debounced level per channel
- rise_pulse  out  CHANNELS  one-cycle pulse when stable_out[i] goes 0→1
- fall_pulse  out  CHANNELS  one-cycle pulse when stable_out[i] goes 1→0
- hold_pulse  out  CHANNELS  one-cycle pulse after HOLD_CNT cycles of continuous stable-high
- any_event  out  1  OR of all rise_pulse and fall_pulse bits, same cycle

## Operation
- Synchroniser: per channel, a SYNC_STAGES shift register sampling noisy_in[i]. Its last stage is s[i].
- Debounce counter cnt[i], width max(1, clog2(DEBOUNCE_CNT)). Each edge:
  - s[i] == stable_out[i]: cnt ← 0.
  - s[i] != stable_out[i] and cnt == DEBOUNCE_CNT-1: stable_out[i] ← s[i], cnt ← 0.
  - otherwise: cnt ← cnt+1.
- The filter is symmetric: the same count applies to rising and falling edges. Any matching sample inside the window restarts it, so glitches shorter than DEBOUNCE_CNT synchronised cycles never change stable_out.
- rise_pulse[i] / fall_pulse[i] are registered on the same edge that updates stable_out[i]. Each is high exactly one cycle. Rise and fall are never high together on one channel.
- Hold counter hcnt[i], width clog2(HOLD_CNT+1):
  - Cleared when stable_out[i] is 0 and on the rise edge.
  - Increments each cycle while stable_out[i] is 1, saturating at HOLD_CNT.
  - hold_pulse[i] fires once, on the edge where hcnt reaches HOLD_CNT.
  - There is no repeat until stable_out[i] falls and rises again.
  - A fall before HOLD_CNT cancels the hold silently.
  - With HOLD_CNT = 0, hold_pulse is tied 0.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulse bits in the same cycle.

## Timing
- Reset (rst_n = 0 at an edge) clears all synchroniser flops, cnt, hcnt, stable_out, rise_pulse, fall_pulse, hold_pulse and any_event to 0.
- Reset is synchronous and takes priority over all other updates. Asserting it mid-count or mid-hold discards progress with no pulse.
- After reset, an input already held high produces a normal rise after the full latency.
- Latency: a new level first sampled at edge E0 appears on stable_out, together with its rise/fall pulse, after edge E(SYNC_STAGES+DEBOUNCE_CNT-1). Defaults: 6th sampling edge (E5).
- hold_pulse is high exactly HOLD_CNT cycles after the rise_pulse cycle, if stable_out stayed 1 throughout.
- The minimum stable_out period between consecutive edges is DEBOUNCE_CNT cycles.
- Input toggling every cycle never changes stable_out for DEBOUNCE_CNT ≥ 2.

## Test plan
- Reset with noisy_in = 4'b1111 held, release at E0 → all outputs 0 through E4. At E5: stable_out = 4'b1111, rise_pulse = 4'b1111, any_event = 1, all for one cycle.
- Ch0 glitch high for 3 cycles (defaults) → stable_out[0], rise_pulse[0] and any_event stay 0 throughout.
- Ch1 held high 30 cycles then low → rise_pulse[1] at E5. hold_pulse[1] exactly 16 cycles later, once. fall_pulse[1] 6 edges after the drop, and stable_out[1] = 0 on the same edge.
- Ch2 high for 10 cycles, with HOLD_CNT = 16 → rise and fall pulses occur, hold_pulse[2] never asserts.
- Ch0 rising while ch3 falling with aligned timing → rise_pulse = 4'b0001 and fall_pulse = 4'b1000 in the same cycle, any_event = 1 for one cycle.
- rst_n pulsed low while ch1 is at hcnt = 10 → all outputs 0 next cycle and no hold_pulse. The input still high yields a fresh rise 6 edges after release.

Source files
------------

// File: rtl/multi_channel_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_debouncer
// Purpose  : N-channel input conditioner. Each channel synchronises a raw
//            asynchronous input, filters it with a symmetric debounce counter,
//            holds the debounced level and emits one-cycle rise, fall and
//            long-press (hold) pulses.
// Ports    : clk         - single clock, all logic on the rising edge
//            rst_n       - synchronous, active-low reset
//            noisy_in    - raw inputs, bit i = channel i
//            stable_out  - debounced level per channel
//            rise_pulse  - one-cycle pulse when stable_out[i] goes 0->1
//            fall_pulse  - one-cycle pulse when stable_out[i] goes 1->0
//            hold_pulse  - one-cycle pulse after HOLD_CNT cycles stable-high
//            any_event   - OR of every rise_pulse and fall_pulse bit
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_debouncer #(
    parameter int CHANNELS     = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 4,
    parameter int HOLD_CNT     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] noisy_in,
    output logic [CHANNELS-1:0] stable_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] hold_pulse,
    output logic                any_event
);

    localparam int C_CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CNT - 1);

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [C_CNT_W-1:0]     r_cnt;
            logic                   r_stable;
            logic                   r_rise;
            logic                   r_fall;
            logic                   w_s;

            // Oldest synchroniser stage is the only one safe to consume.
            assign w_s = r_sync[SYNC_STAGES-1];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], noisy_in[i]};
                end
            end

            // A sample matching the held level restarts the window, so only
            // DEBOUNCE_CNT consecutive differing samples can flip the level.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                    r_rise   <= 1'b0;
                    r_fall   <= 1'b0;
                end else begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (w_s == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_stable <= w_s;
                        r_cnt    <= '0;
                        r_rise   <= w_s;
                        r_fall   <= ~w_s;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign stable_out[i] = r_stable;
            assign rise_pulse[i] = r_rise;
            assign fall_pulse[i] = r_fall;

            if (HOLD_CNT > 0) begin : g_hold
                localparam int C_HOLD_W = $clog2(HOLD_CNT + 1);
                localparam logic [C_HOLD_W-1:0] C_HOLD_MAX  = C_HOLD_W'(HOLD_CNT);
                localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(HOLD_CNT - 1);

                logic [C_HOLD_W-1:0] r_hcnt;
                logic                r_hold;

                // The counter keys off the level held before this edge: it is
                // zero through the rise edge, then counts cycles spent high.
                // Saturation at HOLD_CNT prevents a repeat pulse until the
                // level drops (clearing the count) and rises again.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_hcnt <= '0;
                        r_hold <= 1'b0;
                    end else begin
                        r_hold <= 1'b0;
                        if (!r_stable) begin
                            r_hcnt <= '0;
                        end else if (r_hcnt != C_HOLD_MAX) begin
                            r_hcnt <= r_hcnt + 1'b1;
                            if (r_hcnt == C_HOLD_LAST) begin
                                r_hold <= 1'b1;
                            end
                        end
                    end
                end

                assign hold_pulse[i] = r_hold;
            end else begin : g_no_hold
                assign hold_pulse[i] = 1'b0;
            end
        end
    endgenerate

    assign any_event = |(rise_pulse | fall_pulse);

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_debouncer
// Purpose  : Self-checking bench for multi_channel_debouncer. A timestamp
//            based reference model predicts every output each cycle; directed
//            sequences pin the model with hand-computed literal values, then
//            randomised input toggling with occasional resets follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_debouncer;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 16;
    localparam int HL   = SYNC + DEB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] noisy_in;
    logic [CH-1:0] stable_out;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic [CH-1:0] hold_pulse;
    logic          any_event;

    int checks = 0;
    int fails  = 0;
    bit cmp_en = 1'b0;

    multi_channel_debouncer #(
        .CHANNELS    (CH),
        .SYNC_STAGES (SYNC),
        .DEBOUNCE_CNT(DEB),
        .HOLD_CNT    (HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .noisy_in  (noisy_in),
        .stable_out(stable_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .hold_pulse(hold_pulse),
        .any_event (any_event)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. hist[c][m] is the raw input sampled m+1 edges ago;
    // the value the filter sees at an edge is the one sampled SYNC edges
    // earlier. A new level is accepted when the last DEB filter samples all
    // differ from the held level. Hold is a timestamp check: HOLD edges after
    // the rise edge with no fall in between.
    // ------------------------------------------------------------------
    int            cyc = 0;
    bit            hist [CH][HL];
    logic [CH-1:0] m_stable = '0;
    logic [CH-1:0] m_rise   = '0;
    logic [CH-1:0] m_fall   = '0;
    logic [CH-1:0] m_hold   = '0;
    int            rise_t [CH];
    bit            rise_ok [CH];

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_stable = '0;
            m_rise   = '0;
            m_fall   = '0;
            m_hold   = '0;
            for (int c = 0; c < CH; c++) begin
                rise_ok[c] = 1'b0;
                for (int m = 0; m < HL; m++) hist[c][m] = 1'b0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                bit differ;
                differ = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (hist[c][SYNC-1+j] == m_stable[c]) differ = 1'b0;
                m_hold[c] = (HOLD > 0) && rise_ok[c] && ((cyc - rise_t[c]) == HOLD);
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (differ) begin
                    m_stable[c] = ~m_stable[c];
                    if (m_stable[c]) begin
                        m_rise[c]  = 1'b1;
                        rise_t[c]  = cyc;
                        rise_ok[c] = 1'b1;
                    end else begin
                        m_fall[c]  = 1'b1;
                        rise_ok[c] = 1'b0;
                    end
                end
                for (int m = HL-1; m > 0; m--) hist[c][m] = hist[c][m-1];
                hist[c][0] = noisy_in[c];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h edge=%0d", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_stable", 32'(stable_out), 32'(m_stable));
            chk("model_rise",   32'(rise_pulse), 32'(m_rise));
            chk("model_fall",   32'(fall_pulse), 32'(m_fall));
            chk("model_hold",   32'(hold_pulse), 32'(m_hold));
            chk("model_any",    32'(any_event),  32'(|(m_rise | m_fall)));
        end
    end

    // One active edge, then land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nr, nf, nh;
        logic [CH-1:0] held;

        rst_n    = 1'b0;
        noisy_in = '0;
        @(negedge clk);
        // Reset with all inputs already high.
        noisy_in = 4'b1111;
        tick();
        cmp_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6) begin
                chk("rst_rel_stable", 32'(stable_out), 32'h0);
                chk("rst_rel_rise",   32'(rise_pulse), 32'h0);
                chk("rst_rel_any",    32'(any_event),  32'h0);
            end else if (k == 6) begin
                chk("first_rise_stable", 32'(stable_out), 32'hF);
                chk("first_rise_pulse",  32'(rise_pulse), 32'hF);
                chk("first_rise_any",    32'(any_event),  32'h1);
            end else begin
                chk("rise_one_cycle", 32'(rise_pulse), 32'h0);
                chk("any_one_cycle",  32'(any_event),  32'h0);
            end
        end
        // Hold fires exactly HOLD cycles after the rise cycle (tick 6 -> 22).
        for (int k = 8; k <= 23; k++) begin
            tick();
            chk("hold_timing", 32'(hold_pulse), (k == 22) ? 32'hF : 32'h0);
        end
        // Drop ch1: fall on the 6th edge, level low on the same edge.
        noisy_in = 4'b1101;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("ch1_fall_pulse",  32'(fall_pulse), (k == 6) ? 32'h2 : 32'h0);
            chk("ch1_fall_stable", 32'(stable_out), (k == 6) ? 32'hD : 32'hF);
        end
        noisy_in = 4'b0000;
        repeat (10) tick();
        // Ch0 glitch shorter than the debounce window.
        noisy_in = 4'b0001;
        for (int k = 1; k <= 13; k++) begin
            if (k == 4) noisy_in = 4'b0000;
            tick();
            chk("glitch_stable", 32'(stable_out), 32'h0);
            chk("glitch_rise",   32'(rise_pulse), 32'h0);
            chk("glitch_any",    32'(any_event),  32'h0);
        end
        // Ch2 high for 10 cycles: rise and fall, no hold.
        nr = 0; nf = 0; nh = 0;
        noisy_in = 4'b0100;
        for (int k = 1; k <= 40; k++) begin
            if (k == 11) noisy_in = 4'b0000;
            tick();
            nr += int'(rise_pulse[2]);
            nf += int'(fall_pulse[2]);
            nh += int'(hold_pulse[2]);
        end
        chk("ch2_rises", 32'(nr), 32'd1);
        chk("ch2_falls", 32'(nf), 32'd1);
        chk("ch2_holds", 32'(nh), 32'd0);
        // Ch0 rising aligned with ch3 falling.
        noisy_in = 4'b1000;
        repeat (8) tick();
        noisy_in = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) begin
                chk("simul_rise", 32'(rise_pulse), 32'h1);
                chk("simul_fall", 32'(fall_pulse), 32'h8);
                chk("simul_any",  32'(any_event),  32'h1);
            end else begin
                chk("simul_any_quiet", 32'(any_event), 32'h0);
            end
        end
        // Ch1 rises, reset at hcnt = 10, fresh rise after release.
        noisy_in = 4'b0010;
        repeat (16) tick();
        rst_n = 1'b0;
        tick();
        chk("midhold_rst_stable", 32'(stable_out), 32'h0);
        chk("midhold_rst_pulses", 32'({rise_pulse, fall_pulse, hold_pulse}), 32'h0);
        chk("midhold_rst_any",    32'(any_event),  32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            tick();
            chk("post_rst_hold", 32'(hold_pulse), (k == 22) ? 32'h2 : 32'h0);
            if (k <= 6)
                chk("post_rst_rise", 32'(rise_pulse), (k == 6) ? 32'h2 : 32'h0);
        end
        // Input toggling every cycle never moves the level.
        for (int k = 0; k < 20; k++) begin
            noisy_in = (k % 2 == 0) ? 4'b0000 : 4'b1111;
            tick();
            chk("toggle_stable", 32'(stable_out), 32'h2);
        end
        noisy_in = 4'b0000;
        repeat (10) tick();
        // Randomised phase: slow random toggles per channel, rare resets.
        held = '0;
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 5) == 0) held[c] = ~held[c];
            noisy_in = held;
            rst_n    = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n = 1'b1;
        repeat (5) tick();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
